mul_rr_scheduler: RTL and testbench

//   Shares one registered multiplier (1-cycle latency, async active-low reset) among N_REQ requesters.

---
 rtl/mul_rr_scheduler_if.sv | 36 +++
 rtl/mul_rr_scheduler.sv | 117 +++++++++++
 tb/tb_mul_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_scheduler_if
// Brief    : Request, multiplier and response bundle for mul_rr_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_rr_scheduler_if #(
    parameter int A_W   = 4,
    parameter int B_W   = 3,
    parameter int C_W   = A_W + B_W,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]     req_vld;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [N_REQ-1:0]     req_rdy;
    logic [A_W-1:0]       mul_a;
    logic [B_W-1:0]       mul_b;
    logic [C_W-1:0]       mul_result;
    logic                 rsp_vld;
    logic [ID_W-1:0]      rsp_id;
    logic [C_W-1:0]       rsp_data;
    logic                 rsp_rdy;

    modport slave (
        input  req_vld, req_a, req_b, mul_result, rsp_rdy,
        output req_rdy, mul_a, mul_b, rsp_vld, rsp_id, rsp_data
    );

    modport master (
        output req_vld, req_a, req_b, mul_result, rsp_rdy,
        input  req_rdy, mul_a, mul_b, rsp_vld, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_scheduler
// Brief    : Round-robin sharing of one registered multiplier among N_REQ
//            requesters, returning ID-tagged products over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module mul_rr_scheduler #(
    parameter int A_W   = 4,
    parameter int B_W   = 3,
    parameter int C_W   = A_W + B_W,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_rr_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [A_W-1:0]  r_mul_a;
    logic [B_W-1:0]  r_mul_b;
    logic            r_rsp_vld;
    logic [ID_W-1:0] r_rsp_id;
    logic [C_W-1:0]  r_rsp_data;

    logic [A_W-1:0]   w_a_arr [N_REQ];
    logic [B_W-1:0]   w_b_arr [N_REQ];
    logic [N_REQ-1:0] w_grant;
    logic             w_win_vld;
    logic [ID_W-1:0]  w_win_id;
    logic [ID_W-1:0]  w_idx;
    logic [A_W-1:0]   w_win_a;
    logic [B_W-1:0]   w_win_b;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_a_arr[g] = bus.req_a[g*A_W +: A_W];
            assign w_b_arr[g] = bus.req_b[g*B_W +: B_W];
        end
    endgenerate

    // First requesting ID found walking upward from the one after the last grant.
    always_comb begin
        w_grant   = '0;
        w_win_vld = 1'b0;
        w_win_id  = '0;
        w_idx     = '0;
        w_win_a   = '0;
        w_win_b   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_win_vld && bus.req_vld[w_idx]) begin
                w_win_vld      = 1'b1;
                w_win_id       = w_idx;
                w_win_a        = w_a_arr[w_idx];
                w_win_b        = w_b_arr[w_idx];
                w_grant[w_idx] = 1'b1;
            end
        end
    end

    // Gated by rst_n so no grant is offered while reset is held.
    assign bus.req_rdy  = (rst_n && (r_state == S_IDLE)) ? w_grant : '0;
    assign bus.mul_a    = r_mul_a;
    assign bus.mul_b    = r_mul_b;
    assign bus.rsp_vld  = r_rsp_vld;
    assign bus.rsp_id   = r_rsp_id;
    assign bus.rsp_data = r_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= ID_W'(N_REQ - 1);
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_mul_a <= w_win_a;
                        r_mul_b <= w_win_b;
                        r_ptr   <= w_win_id;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: r_state <= S_CAPT;
                S_CAPT: begin
                    r_rsp_data <= bus.mul_result;
                    r_rsp_id   <= r_ptr;
                    r_rsp_vld  <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_rdy) begin
                        r_rsp_vld <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_rr_scheduler
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_rr_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    mul_rr_scheduler_if #(.A_W(4), .B_W(3), .C_W(7), .N_REQ(4), .ID_W(2)) bus ();

    mul_rr_scheduler #(.A_W(4), .B_W(3), .C_W(7), .N_REQ(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External registered multiplier shared by the scheduler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.mul_result <= '0;
        else        bus.mul_result <= 7'(bus.mul_a) * 7'(bus.mul_b);
    end

    int checks = 0;
    int errors = 0;
    bit pend [N];
    bit keep [N];
    int opa  [N];
    int opb  [N];
    bit rsp_rdy_d = 1'b1;
    bit rand_mode = 1'b0;
    int m_phase = -1;
    int m_ptr   = N - 1;
    int m_id, m_data, m_acc;
    int n_rsp = 0;
    int last_id, last_data;
    int grants [$];
    int snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_vld[i]       = pend[i];
            bus.req_a[i*4 +: 4]  = 4'(opa[i]);
            bus.req_b[i*3 +: 3]  = 3'(opb[i]);
        end
        bus.rsp_rdy = rsp_rdy_d;
    endtask

    // Model phase: -1 idle, 1/2 computing, 3 response presented.
    task automatic model_eval();
        int win;
        win = -1;
        if (m_phase < 0) begin
            for (int i = m_ptr + 1; i < N; i++) if (pend[i] && win < 0) win = i;
            for (int i = 0; i < N; i++)         if (pend[i] && win < 0) win = i;
        end
        chk("req_rdy", 32'(bus.req_rdy), (win >= 0) ? 32'(1 << win) : 32'd0);
        chk("rsp_vld", 32'(bus.rsp_vld), 32'(m_phase == 3));
        if (m_phase == 3) begin
            chk("rsp_id",   32'(bus.rsp_id),   32'(m_id));
            chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
        end
        chk("no_x", 32'($isunknown({bus.req_rdy, bus.mul_a, bus.mul_b,
                                    bus.rsp_vld, bus.rsp_id, bus.rsp_data})), 32'd0);
        m_acc = -1;
        if (m_phase < 0) begin
            if (win >= 0) begin
                m_acc   = win;
                m_ptr   = win;
                m_id    = win;
                m_data  = opa[win] * opb[win];
                m_phase = 1;
                grants.push_back(win);
            end
        end else if (m_phase < 3) begin
            m_phase++;
        end else if (rsp_rdy_d) begin
            last_id   = int'(bus.rsp_id);
            last_data = int'(bus.rsp_data);
            m_phase   = -1;
            n_rsp++;
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(negedge clk);
            model_eval();
            @(posedge clk);
            #1;
            if (m_acc >= 0) begin
                if (keep[m_acc]) begin
                    opa[m_acc] = $urandom_range(0, 15);
                    opb[m_acc] = $urandom_range(0, 7);
                end else begin
                    pend[m_acc] = 1'b0;
                end
            end
            if (rand_mode) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        opa[i]  = $urandom_range(0, 15);
                        opb[i]  = $urandom_range(0, 7);
                    end
                end
                rsp_rdy_d = ($urandom_range(0, 3) != 0);
            end
            drive();
        end
    endtask

    task automatic wait_phase(input int ph, input string tag);
        int t;
        t = 0;
        while (m_phase != ph && t < 20) begin
            cycle(1);
            t++;
        end
        chk(tag, 32'(m_phase), 32'(ph));
    endtask

    task automatic drain();
        int t;
        t = 0;
        rand_mode = 1'b0;
        rsp_rdy_d = 1'b1;
        for (int i = 0; i < N; i++) keep[i] = 1'b0;
        drive();
        while ((pend[0] || pend[1] || pend[2] || pend[3] || m_phase >= 0) && t < 80) begin
            cycle(1);
            t++;
        end
        chk("drain_timeout", 32'(t < 80), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_rdy",  32'(bus.req_rdy),  32'd0);
        chk("rst_mul_a",    32'(bus.mul_a),    32'd0);
        chk("rst_mul_b",    32'(bus.mul_b),    32'd0);
        chk("rst_rsp_vld",  32'(bus.rsp_vld),  32'd0);
        chk("rst_rsp_id",   32'(bus.rsp_id),   32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_phase = -1;
        m_ptr   = N - 1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; keep[i] = 1'b0; opa[i] = 0; opb[i] = 0;
        end
        rst_n = 1'b1;
        drive();
        #2;
        do_reset();

        // All four requesters continuously requesting
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; keep[i] = 1'b1;
            opa[i] = $urandom_range(0, 15); opb[i] = $urandom_range(0, 7);
        end
        drive();
        grants.delete();
        snap = n_rsp;
        cycle(24);
        chk("t2_rsp_count", 32'(n_rsp - snap), 32'd6);
        drain();
        chk("t2_g0", 32'(grants[0]), 32'd0);
        chk("t2_g1", 32'(grants[1]), 32'd1);
        chk("t2_g2", 32'(grants[2]), 32'd2);
        chk("t2_g3", 32'(grants[3]), 32'd3);
        chk("t2_g4", 32'(grants[4]), 32'd0);
        chk("t2_g5", 32'(grants[5]), 32'd1);

        // Requesters 1 and 3, starting just after a grant to 3
        pend[3] = 1'b1; opa[3] = 6; opb[3] = 3;
        drive();
        wait_phase(1, "t3_first_grant");
        grants.delete();
        pend[1] = 1'b1; pend[3] = 1'b1; keep[1] = 1'b1; keep[3] = 1'b1;
        opa[1] = 11; opb[1] = 5;
        drive();
        cycle(12);
        chk("t3_g0", 32'(grants[0]), 32'd1);
        chk("t3_g1", 32'(grants[1]), 32'd3);
        chk("t3_g2", 32'(grants[2]), 32'd1);
        drain();

        // Single request from requester 2
        pend[2] = 1'b1; opa[2] = 15; opb[2] = 7;
        drive();
        grants.delete();
        cycle(5);
        chk("t1_grant", 32'(grants[0]), 32'd2);
        chk("t1_id",    32'(last_id),   32'd2);
        chk("t1_data",  32'(last_data), 32'd105);

        // Six cycles of backpressure with others pending
        pend[0] = 1'b1; opa[0] = 4;  opb[0] = 4;
        pend[1] = 1'b1; opa[1] = 13; opb[1] = 2;
        pend[2] = 1'b1; opa[2] = 7;  opb[2] = 6;
        drive();
        wait_phase(3, "t4_reach_resp");
        rsp_rdy_d = 1'b0;
        drive();
        grants.delete();
        cycle(6);
        chk("t4_no_grant", 32'(grants.size()), 32'd0);
        rsp_rdy_d = 1'b1;
        drive();
        cycle(2);
        chk("t4_grant_after", 32'(grants.size()), 32'd1);
        drain();

        // Extreme operands on requester 1
        pend[1] = 1'b1; opa[1] = 0; opb[1] = 7; drive();
        cycle(4);
        chk("t6_a0", 32'(last_data), 32'd0);
        pend[1] = 1'b1; opa[1] = 15; opb[1] = 0; drive();
        cycle(4);
        chk("t6_b0", 32'(last_data), 32'd0);
        pend[1] = 1'b1; opa[1] = 15; opb[1] = 7; drive();
        cycle(4);
        chk("t6_max", 32'(last_data), 32'h69);

        // Reset while the multiplier is computing 9*5
        pend[2] = 1'b1; opa[2] = 9; opb[2] = 5;
        drive();
        wait_phase(1, "t5_reach_calc");
        pend[0] = 1'b1; opa[0] = 3; opb[0] = 2;
        pend[3] = 1'b1; opa[3] = 5; opb[3] = 1;
        drive();
        do_reset();
        grants.delete();
        cycle(4);
        chk("t5_first_grant", 32'(grants[0]), 32'd0);
        chk("t5_rsp_id",      32'(last_id),   32'd0);
        chk("t5_rsp_data",    32'(last_data), 32'd6);
        drain();

        // Random traffic with random response backpressure
        rand_mode = 1'b1;
        cycle(400);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
